// File: rtl/lh_msg_driver.sv
// Initiator for the light-hash core: buffers one upstream message, streams it out one character
// per cycle and checks the returned digest. Build macro LH_DRV_PRECHECK_EN adds load-time filtering.

module lh_msg_driver #(
    parameter int MSG_DEPTH = 32,
    parameter int TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_char,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    input  logic [63:0] exp_digest,
    output logic [7:0]  ptxt_char,
    output logic        ptxt_valid,
    input  logic [63:0] digest_char,
    input  logic        digest_ready,
    input  logic        err_invalid_ptxt_char,
    output logic        busy,
    output logic        done,
    output logic        match,
    output logic [2:0]  err_flags
);

    localparam int PW = $clog2(MSG_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(MSG_DEPTH);
    localparam logic [TW-1:0] TMO_LAST_C = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SEND   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

`ifdef LH_DRV_PRECHECK_EN
    function automatic logic is_alnum(input logic [7:0] c);
        is_alnum = ((c >= 8'h30) && (c <= 8'h39)) ||
                   ((c >= 8'h41) && (c <= 8'h5A)) ||
                   ((c >= 8'h61) && (c <= 8'h7A));
    endfunction
`endif

    state_t        state_r, state_s;
    logic [7:0]    buf_r [MSG_DEPTH];
    logic [CW-1:0] count_r, count_d, count_inc_s;
    logic [PW-1:0] rd_ptr_r, rd_ptr_d;
    logic [TW-1:0] tmo_cnt_r, tmo_cnt_d;
    logic [63:0]   exp_digest_r, exp_digest_d;
    logic [7:0]    ptxt_char_r, ptxt_char_d;
    logic          ptxt_valid_r, ptxt_valid_d;
    logic          done_r, done_d;
    logic          match_r, match_d;
    logic [2:0]    err_flags_r, err_flags_d, err_base_s, err_next_s;
    logic          in_ready_s, hs_s, last_hs_s, room_s, char_ok_s, wr_en_s;
    logic          ovf_s, inv_s, tmo_s, send_last_s;

    // Handshake, buffer-space and error-event decode
    always_comb begin
        in_ready_s = (state_r == ST_IDLE) || (state_r == ST_LOAD);
        hs_s       = in_valid && in_ready_s;
        last_hs_s  = hs_s && in_last;
        room_s     = (count_r < DEPTH_C);
`ifdef LH_DRV_PRECHECK_EN
        char_ok_s  = is_alnum(in_char);
        inv_s      = hs_s && room_s && !char_ok_s;
`else
        char_ok_s  = 1'b1;
        // The core flag lags its character by one cycle, hence the skewed sampling window
        inv_s      = err_invalid_ptxt_char &&
                     (((state_r == ST_SEND) && (rd_ptr_r != {PW{1'b0}})) ||
                      ((state_r == ST_WAIT) && (tmo_cnt_r == {TW{1'b0}})));
`endif
        wr_en_s     = hs_s && room_s && char_ok_s;
        ovf_s       = hs_s && !room_s && !in_last;
        tmo_s       = (state_r == ST_WAIT) && !digest_ready && (tmo_cnt_r == TMO_LAST_C);
        count_inc_s = count_r + CW'(wr_en_s);
        err_base_s  = ((state_r == ST_IDLE) && hs_s) ? 3'b000 : err_flags_r;
        err_next_s  = err_base_s | {tmo_s, inv_s, ovf_s};
        send_last_s = ((CW'(rd_ptr_r) + CW'(1)) == count_r);
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_LOAD: begin
                if (last_hs_s) begin
                    state_s = (count_inc_s == {CW{1'b0}}) ? ST_WAIT : ST_SEND;
                end else if (hs_s) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = state_r;
                end
            end
            ST_SEND:   state_s = send_last_s ? ST_WAIT : ST_SEND;
            ST_WAIT:   state_s = (digest_ready || (tmo_cnt_r == TMO_LAST_C)) ? ST_REPORT : ST_WAIT;
            ST_REPORT: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        count_d      = count_inc_s;
        rd_ptr_d     = rd_ptr_r;
        tmo_cnt_d    = {TW{1'b0}};
        exp_digest_d = last_hs_s ? exp_digest : exp_digest_r;
        ptxt_char_d  = ptxt_char_r;
        ptxt_valid_d = 1'b0;
        done_d       = 1'b0;
        match_d      = match_r;
        err_flags_d  = err_next_s;
        case (state_r)
            ST_IDLE, ST_LOAD: begin
                match_d  = ((state_r == ST_IDLE) && hs_s) ? 1'b0 : match_r;
                rd_ptr_d = {PW{1'b0}};
                // First character leaves on the handshake edge; bypass the buffer for one-char messages
                if (state_s == ST_SEND) begin
                    ptxt_valid_d = 1'b1;
                    ptxt_char_d  = (count_r == {CW{1'b0}}) ? in_char : buf_r[{PW{1'b0}}];
                end else begin
                    ptxt_valid_d = 1'b0;
                end
            end
            ST_SEND: begin
                if (send_last_s) begin
                    ptxt_valid_d = 1'b0;
                end else begin
                    rd_ptr_d     = rd_ptr_r + PW'(1);
                    ptxt_char_d  = buf_r[rd_ptr_r + PW'(1)];
                    ptxt_valid_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (state_s == ST_REPORT) begin
                    done_d  = 1'b1;
                    match_d = digest_ready && (digest_char == exp_digest_r) && (err_next_s == 3'b000);
                end else begin
                    tmo_cnt_d = tmo_cnt_r + TW'(1);
                end
            end
            ST_REPORT: begin
                count_d  = {CW{1'b0}};
                rd_ptr_d = {PW{1'b0}};
            end
            default: begin
                count_d  = {CW{1'b0}};
                rd_ptr_d = {PW{1'b0}};
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Counters, latched digest and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r      <= {CW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            tmo_cnt_r    <= {TW{1'b0}};
            exp_digest_r <= 64'h0;
            ptxt_char_r  <= 8'h00;
            ptxt_valid_r <= 1'b0;
            done_r       <= 1'b0;
            match_r      <= 1'b0;
            err_flags_r  <= 3'b000;
        end else begin
            count_r      <= count_d;
            rd_ptr_r     <= rd_ptr_d;
            tmo_cnt_r    <= tmo_cnt_d;
            exp_digest_r <= exp_digest_d;
            ptxt_char_r  <= ptxt_char_d;
            ptxt_valid_r <= ptxt_valid_d;
            done_r       <= done_d;
            match_r      <= match_d;
            err_flags_r  <= err_flags_d;
        end
    end

    // Message buffer storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            buf_r[count_r[PW-1:0]] <= in_char;
        end
    end

    assign in_ready   = in_ready_s;
    assign busy       = (state_r != ST_IDLE);
    assign ptxt_char  = ptxt_char_r;
    assign ptxt_valid = ptxt_valid_r;
    assign done       = done_r;
    assign match      = match_r;
    assign err_flags  = err_flags_r;

endmodule

// File: tb/tb_lh_msg_driver.sv
// Scoreboard bench for lh_msg_driver: stimulus pushes expectations from a message-level model,
// a negedge monitor pops and compares; a small core model answers with digests and char flags.

module tb_lh_msg_driver;

    localparam int MSG_DEPTH = 32;
    localparam int TIMEOUT   = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_char = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [63:0] exp_digest = 64'h0;
    logic [7:0]  ptxt_char;
    logic        ptxt_valid;
    logic [63:0] digest_char = 64'h0;
    logic        digest_ready = 1'b0;
    logic        err_invalid_ptxt_char = 1'b0;
    logic        busy, done, match;
    logic [2:0]  err_flags;

    lh_msg_driver #(.MSG_DEPTH(MSG_DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_char(in_char), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .exp_digest(exp_digest),
        .ptxt_char(ptxt_char), .ptxt_valid(ptxt_valid),
        .digest_char(digest_char), .digest_ready(digest_ready),
        .err_invalid_ptxt_char(err_invalid_ptxt_char),
        .busy(busy), .done(done), .match(match), .err_flags(err_flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         match;
        logic [2:0] err;
        int         lat;
        int         nchars;
    } res_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  msg_q[$];
    logic [7:0]  exp_chars[$];
    res_t        exp_res[$];
    res_t        r_hold;
    int          core_delay = 0;
    logic [63:0] core_digest = 64'h0;
    logic [63:0] exp_d_v = 64'h0;
    int          hs_cyc = 0, first_cyc = 0, last_cyc = 0, nvalid = 0;

    function automatic bit alnum(input logic [7:0] c);
        return ((c >= 8'h30) && (c <= 8'h39)) || ((c >= 8'h41) && (c <= 8'h5A)) ||
               ((c >= 8'h61) && (c <= 8'h7A));
    endfunction

    function automatic logic [7:0] rand_alnum();
        int r;
        r = $urandom_range(0, 61);
        if (r < 10) return 8'(8'h30 + r);
        else if (r < 36) return 8'(8'h41 + r - 10);
        else return 8'(8'h61 + r - 36);
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic set_str(input string s);
        msg_q.delete();
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
    endtask

    // Message-level reference: which characters reach the core and what the verdict must be
    task automatic prepare(input int d, input bit corrupt);
        logic [7:0] sent[$];
        bit ovf, inv, tmo;
        res_t r;
        ovf = 1'b0;
        inv = 1'b0;
        for (int i = 0; i < msg_q.size(); i++) begin
            if (sent.size() < MSG_DEPTH) begin
`ifdef LH_DRV_PRECHECK_EN
                if (!alnum(msg_q[i])) inv = 1'b1;
                else sent.push_back(msg_q[i]);
`else
                sent.push_back(msg_q[i]);
`endif
            end else if (i != msg_q.size() - 1) begin
                ovf = 1'b1;
            end
        end
`ifndef LH_DRV_PRECHECK_EN
        foreach (sent[i]) if (!alnum(sent[i])) inv = 1'b1;
`endif
        tmo      = (d < 2) || (d > TIMEOUT);
        r.err    = {tmo, inv, ovf};
        r.match  = !tmo && !corrupt && !inv && !ovf;
        r.lat    = tmo ? TIMEOUT + 1 : d + 1;
        r.nchars = sent.size();
        foreach (sent[i]) exp_chars.push_back(sent[i]);
        exp_res.push_back(r);
        r_hold      = r;
        exp_d_v     = {$urandom(), $urandom()};
        core_delay  = d;
        core_digest = corrupt ? (exp_d_v ^ 64'h1) : exp_d_v;
    endtask

    // Drives msg_q upstream with random bubbles; starts and ends just after a rising edge
    task automatic send_chars();
        for (int i = 0; i < msg_q.size(); i++) begin
            if ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid   = 1'b1;
            in_char    = msg_q[i];
            in_last    = (i == msg_q.size() - 1);
            exp_digest = in_last ? exp_d_v : {$urandom(), $urandom()};
            @(negedge clk);
            chk("in_ready", 64'(in_ready), 64'(1));
            @(posedge clk); #1;
            if (in_last) hs_cyc = cyc;
        end
        in_valid   = 1'b0;
        in_last    = 1'b0;
        exp_digest = ~exp_d_v;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_res.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_res.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done within %0d cycles, expected done", n);
            exp_res.delete();
            exp_chars.delete();
        end
        @(negedge clk); #1;
        chk("done_pulse", 64'(done), 64'(0));
        chk("match_hold", 64'(match), 64'(r_hold.match));
        chk("err_hold", 64'(err_flags), 64'(r_hold.err));
        @(posedge clk); #1;
        chk("busy_idle", 64'(busy), 64'(0));
    endtask

    task automatic run_msg(input int d, input bit corrupt);
        prepare(d, corrupt);
        send_chars();
        wait_done();
    endtask

    // Hash-core model: flags non-alnum characters one cycle late, answers d cycles after the last char
    initial begin
        int  since;
        bit  armed, inv_nxt, resp_nxt;
        since = 0;
        armed = 1'b0;
        forever begin
            @(negedge clk);
            inv_nxt  = 1'b0;
            resp_nxt = 1'b0;
            if (!rst_n) begin
                armed = 1'b0;
            end else begin
                inv_nxt = ptxt_valid && !alnum(ptxt_char);
                if (ptxt_valid) begin
                    armed = 1'b1;
                    since = 0;
                end else if (armed) begin
                    since++;
                    if (core_delay >= 2 && since == core_delay - 1) begin
                        resp_nxt = 1'b1;
                        armed    = 1'b0;
                    end else if (since > 200) begin
                        armed = 1'b0;
                    end
                end
            end
            @(posedge clk); #1;
            err_invalid_ptxt_char = inv_nxt;
            digest_ready          = resp_nxt;
            digest_char           = resp_nxt ? core_digest : ~core_digest;
        end
    end

    // Monitor: pops expected characters and verdicts as the DUT presents them
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ptxt_valid) begin
                    if (nvalid == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    nvalid++;
                    if (exp_chars.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL ptxt_extra: got char %h, expected no ptxt_valid", ptxt_char);
                    end else begin
                        chk("ptxt_char", 64'(ptxt_char), 64'(exp_chars.pop_front()));
                    end
                end
                if (done) begin
                    if (exp_res.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL done_spurious: got done=1, expected 0");
                    end else begin
                        r = exp_res.pop_front();
                        chk("match", 64'(match), 64'(r.match));
                        chk("err_flags", 64'(err_flags), 64'(r.err));
                        chk("busy_report", 64'(busy), 64'(1));
                        chk("nchars", 64'(nvalid), 64'(r.nchars));
                        chk("contiguous", 64'(last_cyc - first_cyc + 1), 64'(r.nchars));
                        chk("first_latency", 64'(first_cyc - hs_cyc), 64'(0));
                        chk("done_latency", 64'(cyc - last_cyc), 64'(r.lat));
                    end
                    nvalid = 0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected $finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int len, k, d;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ptxt_valid", 64'(ptxt_valid), 64'(0));
        chk("rst_ptxt_char", 64'(ptxt_char), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_match", 64'(match), 64'(0));
        chk("rst_err", 64'(err_flags), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        rst_n = 1'b1;
        @(posedge clk); #1;

        set_str("abc");  run_msg(3, 1'b0);
        set_str("abc");  run_msg(3, 1'b1);
        msg_q.delete();
        for (int i = 0; i < 40; i++) msg_q.push_back(rand_alnum());
        run_msg(5, 1'b0);
        set_str("a#b");  run_msg(4, 1'b0);
        set_str("xyz9"); run_msg(0, 1'b0);
        set_str("Q1");   run_msg(TIMEOUT, 1'b0);
        set_str("Q2");   run_msg(TIMEOUT + 1, 1'b0);
        set_str("Z");    run_msg(2, 1'b0);
        msg_q.delete();
        for (int i = 0; i < MSG_DEPTH; i++) msg_q.push_back(rand_alnum());
        run_msg(4, 1'b0);

        // Reset in the middle of SEND: outputs drop at once and no verdict follows
        set_str("hello123");
        prepare(3, 1'b0);
        send_chars();
        @(negedge clk);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ptxt_valid", 64'(ptxt_valid), 64'(0));
        chk("rst_mid_busy", 64'(busy), 64'(0));
        chk("rst_mid_in_ready", 64'(in_ready), 64'(1));
        exp_chars.delete();
        exp_res.delete();
        nvalid = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_done_after_reset", 64'(done), 64'(0));
        end
        @(posedge clk); #1;
        set_str("abc");  run_msg(3, 1'b0);

        for (int m = 0; m < 10; m++) begin
            len = $urandom_range(1, 40);
            msg_q.delete();
            msg_q.push_back(rand_alnum());
            for (int i = 1; i < len; i++)
                msg_q.push_back(($urandom_range(0, 9) == 0) ? 8'h23 : rand_alnum());
            k = $urandom_range(0, 9);
            if (k < 7) d = $urandom_range(2, 10);
            else if (k == 7) d = TIMEOUT;
            else if (k == 8) d = TIMEOUT + 1;
            else d = 0;
            run_msg(d, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
